mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Pipeline MEM stage between EX/MEM and WB. Issues loads/stores to data memory over a
//  req/ack handshake and stalls upstream while memory is busy. Aligns load data and
//  sign/zero-extends it. Registers the result into the MEM/WB bundle (memwb_t) that
//  wb_stage consumes. Detects misaligned accesses and suppresses them.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported (byte lanes are fixed at 4)
// PORTS
//  clk        in   1     single clock; all state updates on posedge
//  reset      in   1     synchronous, active-high reset
//  inputs     in   exmem_t  fields: ALUResult[31:0], WriteData[31:0], PCPlus4[31:0],
//                        ImmExt[31:0], Rd[4:0], RegWrite, ResultSrc[1:0], MemRead,
//                        MemWrite, funct3[2:0], valid
//  flushM     in   1     kill the current MEM-stage instruction
//  dmem_req   out  1     memory request valid
//  dmem_we    out  1     1 = store, 0 = load
//  dmem_addr  out  32    word address: {ALUResult[31:2],2'b00}
//  dmem_be    out  4     byte enables
//  dmem_wdata out  32    store data, replicated into the enabled lanes
//  dmem_ack   in   1     request accepted/completed; rdata valid this cycle for loads
//  dmem_rdata in   32    load word
//  StallM     out  1     holds IF..EX/MEM upstream this cycle
//  misalignM  out  1     1-cycle pulse: misaligned access detected (to trap logic)
//  outputs    out  memwb_t  ALUResult, load_data, PCPlus4, ImmExt, Rd, RegWrite, ResultSrc
// BEHAVIOUR
//  - Reset: outputs cleared to all-zero (RegWrite=0, Rd=0); FSM to IDLE.
//    dmem_req, StallM and misalignM are 0 in the cycle after reset.
//  - mem_op = valid & (MemRead|MemWrite) & ~flushM & ~misaligned.
//  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
//    * misalignM=1 for one cycle; no request is issued.
//    * A bubble (RegWrite=0) is registered into MEM/WB.
//  - FSM has two states, IDLE and WAIT.
//    * IDLE: dmem_req = mem_op (combinational from inputs).
//      - mem_op & dmem_ack: access completes with zero wait; stay IDLE.
//      - mem_op & ~dmem_ack: go to WAIT.
//    * WAIT: dmem_req=1; addr, be, wdata and we are held from registered copies.
//      - Stay in WAIT until dmem_ack, then go to IDLE.
//  - StallM = dmem_req & ~dmem_ack.
//    * Upstream holds its EX/MEM register while StallM=1.
//    * While StallM=1, a bubble (RegWrite=0) is clocked into MEM/WB.
//  - MEM/WB register update on each posedge:
//    * completing mem op or non-mem instr: load outputs from inputs.
//    * bubble / invalid / flushM: RegWrite=0, Rd=0.
//  - Load latency: rdata in the ack cycle; load_data is visible at WB the next cycle.
//  - Store lanes:
//    * SB: be = 1<<addr[1:0]
//    * SH: be = addr[1] ? 4'b1100 : 4'b0011
//    * SW: be = 4'b1111
//  - Load extract (funct3): LB 000, LH 001, LW 010, LBU 100, LHU 101.
//    * Lane select uses addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  - Unknown funct3 with MemRead/MemWrite: treated as word (LW/SW).
//  - flushM in WAIT: the pending request stays asserted until ack (no cancel on the bus).
//    The result is discarded as a bubble, then the FSM returns to IDLE.
//  - reset in WAIT: dmem_req drops the next cycle; any late ack is ignored.
// TESTING
//  - ALU op, Rd=5, ALUResult=0x1234, no mem op
//    -> next cycle outputs.Rd=5, RegWrite=1, ALUResult=0x1234; dmem_req=0.
//  - LB at addr 0x103, rdata=0x80FF_FF7F, ack same cycle
//    -> StallM=0, load_data=0xFFFF_FF80 next cycle.
//  - LHU at 0x102, ack delayed 3 cycles
//    -> StallM=1 for 3 cycles with 3 bubbles, then load_data=upper half zero-extended.
//  - SB at 0x201, WriteData=0xAB
//    -> dmem_be=4'b0010, dmem_wdata=0xABABABAB, dmem_addr=0x200, dmem_we=1.
//  - LW at 0x302 -> misalignM=1 for 1 cycle, dmem_req=0, outputs.RegWrite=0.
//  - reset asserted while in WAIT
//    -> next cycle dmem_req=0, StallM=0, outputs all-zero; ack next cycle ignored.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline MEM stage. Issues loads/stores over a req/ack
//                data-memory handshake, stalls upstream while memory is busy,
//                aligns and extends load data, flags misaligned accesses and
//                registers the MEM/WB bundle consumed by wb_stage.
//  Revision    : 1.0 - initial release
// ============================================================================

package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] PCPlus4;
    logic [31:0] ImmExt;
    logic [4:0]  Rd;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic        valid;
  } exmem_t;

  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] load_data;
    logic [31:0] PCPlus4;
    logic [31:0] ImmExt;
    logic [4:0]  Rd;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
  } memwb_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  exmem_t          inputs,
  input  logic            flushM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            StallM,
  output logic            misalignM,
  output memwb_t          outputs
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;
  exmem_t pend_q, pend_d;   // copy of the access held on the bus while waiting
  logic   kill_q, kill_d;   // flush seen while waiting: discard the result
  memwb_t out_q, out_d;

  exmem_t          w_cur;
  logic            w_access;
  logic            w_is_byte;
  logic            w_is_half;
  logic            w_misal;
  logic            w_mem_op;
  logic            w_take;
  logic [15:0]     w_shift;
  logic [XLEN-1:0] w_load;

  // While waiting the bus is driven from the captured copy, otherwise from EX/MEM.
  assign w_cur     = (state_q == S_WAIT) ? pend_q : inputs;
  assign w_access  = w_cur.MemRead | w_cur.MemWrite;
  // funct3 100/101 are only meaningful for loads; any unknown code acts as a word.
  assign w_is_byte = (w_cur.funct3 == 3'b000) | ((w_cur.funct3 == 3'b100) & ~w_cur.MemWrite);
  assign w_is_half = (w_cur.funct3 == 3'b001) | ((w_cur.funct3 == 3'b101) & ~w_cur.MemWrite);
  assign w_misal   = (w_is_half & w_cur.ALUResult[0]) |
                     (~w_is_byte & ~w_is_half & (w_cur.ALUResult[1:0] != 2'b00));
  assign w_mem_op  = (state_q == S_IDLE) & w_cur.valid & w_access & ~flushM & ~w_misal;

  assign dmem_req  = (state_q == S_WAIT) | w_mem_op;
  assign StallM    = dmem_req & ~dmem_ack;
  assign misalignM = (state_q == S_IDLE) & w_cur.valid & w_access & ~flushM & w_misal;
  assign dmem_we   = w_cur.MemWrite;
  assign dmem_addr = {w_cur.ALUResult[31:2], 2'b00};

  // Byte-lane enables and store data replicated across the lanes.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = w_cur.WriteData;
    if (w_is_byte) begin
      dmem_be    = 4'b0001 << w_cur.ALUResult[1:0];
      dmem_wdata = {4{w_cur.WriteData[7:0]}};
    end else if (w_is_half) begin
      dmem_be    = w_cur.ALUResult[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{w_cur.WriteData[15:0]}};
    end
  end

  assign w_shift = 16'(dmem_rdata >> {w_cur.ALUResult[1:0], 3'b000});

  // Load lane select with sign (LB/LH) or zero (LBU/LHU) extension.
  always_comb begin
    w_load = dmem_rdata;
    if (w_is_byte) begin
      w_load = {{24{~w_cur.funct3[2] & w_shift[7]}}, w_shift[7:0]};
    end else if (w_is_half) begin
      w_load = {{16{~w_cur.funct3[2] & w_shift[15]}}, w_shift[15:0]};
    end
  end

  // Handshake FSM next state and the MEM/WB next value (bubble unless an instruction retires).
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    kill_d  = kill_q;
    w_take  = 1'b0;
    out_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (w_mem_op) begin
          if (dmem_ack) begin
            w_take = 1'b1;
          end else begin
            state_d = S_WAIT;
            pend_d  = inputs;
            kill_d  = 1'b0;
          end
        end else if (w_cur.valid & ~w_access & ~flushM) begin
          w_take = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d = S_IDLE;
          kill_d  = 1'b0;
          w_take  = ~kill_q & ~flushM;
        end else if (flushM) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_take) begin
      out_d.ALUResult = w_cur.ALUResult;
      out_d.load_data = w_cur.MemRead ? w_load : '0;
      out_d.PCPlus4   = w_cur.PCPlus4;
      out_d.ImmExt    = w_cur.ImmExt;
      out_d.Rd        = w_cur.Rd;
      out_d.RegWrite  = w_cur.RegWrite;
      out_d.ResultSrc = w_cur.ResultSrc;
    end
  end

  // State, captured access and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      kill_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      kill_q  <= kill_d;
      out_q   <= out_d;
    end
  end

  assign outputs = out_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: directed scenarios plus
//                randomized accesses against a byte-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  exmem_t      inputs;
  logic        flushM;
  logic        dmem_req, dmem_we, dmem_ack, StallM, misalignM;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  memwb_t      outputs;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .inputs(inputs), .flushM(flushM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .misalignM(misalignM), .outputs(outputs)
  );

  function automatic exmem_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd);
    exmem_t e;
    e = '0;
    e.valid = 1'b1; e.MemRead = rd; e.MemWrite = wr; e.funct3 = f3;
    e.ALUResult = addr; e.WriteData = wd; e.Rd = 5'd7; e.RegWrite = rd;
    e.ResultSrc = rd ? 2'b01 : 2'b00; e.PCPlus4 = 32'h1004; e.ImmExt = 32'h10;
    return e;
  endfunction

  // Reference model: access size in bytes from funct3 (unknown codes are words).
  function automatic int unsigned m_size(exmem_t e);
    case (e.funct3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd4:    return e.MemWrite ? 4 : 1;
      3'd5:    return e.MemWrite ? 4 : 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_misaligned(exmem_t e);
    return (e.ALUResult % m_size(e)) != 0;
  endfunction

  function automatic logic [3:0] m_be(exmem_t e);
    int unsigned n;
    n = m_size(e);
    return 4'(((1 << n) - 1) << (e.ALUResult % 4));
  endfunction

  function automatic logic [31:0] m_wdata(exmem_t e);
    logic [31:0] r;
    case (m_size(e))
      1:       r = {24'd0, e.WriteData[7:0]} * 32'h0101_0101;
      2:       r = {16'd0, e.WriteData[15:0]} * 32'h0001_0001;
      default: r = e.WriteData;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] m_load(exmem_t e, logic [31:0] rdata);
    logic [31:0] v, mask;
    int unsigned n;
    n = m_size(e);
    if (n == 4) return rdata;
    v    = rdata >> (8 * (e.ALUResult % 4));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if ((e.funct3 == 3'd0 || e.funct3 == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic memwb_t m_expect(exmem_t e, logic [31:0] rdata);
    memwb_t x;
    x = '0;
    x.ALUResult = e.ALUResult; x.PCPlus4 = e.PCPlus4; x.ImmExt = e.ImmExt;
    x.Rd = e.Rd; x.RegWrite = e.RegWrite; x.ResultSrc = e.ResultSrc;
    x.load_data = e.MemRead ? m_load(e, rdata) : 32'd0;
    return x;
  endfunction

  task automatic test_reset();
    reset = 1'b1; inputs = '0; flushM = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    vec++; if (outputs !== '0) begin miss++; $display("FAIL reset_outputs got %h exp 0", outputs); end
    vec++; if ({dmem_req, StallM, misalignM} !== 3'b000) begin
      miss++; $display("FAIL reset_ctrl got %b exp 000", {dmem_req, StallM, misalignM}); end
  endtask

  task automatic test_alu();
    exmem_t e;
    e = '0; e.valid = 1'b1; e.RegWrite = 1'b1; e.Rd = 5'd5; e.ALUResult = 32'h1234;
    @(negedge clk); inputs = e; #1;
    vec++; if (dmem_req !== 1'b0) begin miss++; $display("FAIL alu_req got %b exp 0", dmem_req); end
    @(posedge clk); #1;
    vec++; if ({outputs.Rd, outputs.RegWrite, outputs.ALUResult} !== {5'd5, 1'b1, 32'h1234}) begin
      miss++; $display("FAIL alu_out got rd=%0d rw=%b alu=%h exp rd=5 rw=1 alu=1234",
                       outputs.Rd, outputs.RegWrite, outputs.ALUResult); end
    @(negedge clk); inputs = '0;
  endtask

  task automatic test_lb();
    @(negedge clk); inputs = mk(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    dmem_rdata = 32'h80FF_FF7F; dmem_ack = 1'b1; #1;
    vec++; if ({dmem_req, StallM} !== 2'b10) begin
      miss++; $display("FAIL lb_req_stall got %b exp 10", {dmem_req, StallM}); end
    @(posedge clk); #1;
    vec++; if ({outputs.RegWrite, outputs.load_data} !== {1'b1, 32'hFFFF_FF80}) begin
      miss++; $display("FAIL lb_data got rw=%b %h exp rw=1 ffffff80", outputs.RegWrite, outputs.load_data); end
    @(negedge clk); inputs = '0; dmem_ack = 1'b0;
  endtask

  task automatic test_lhu_delay();
    @(negedge clk); inputs = mk(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
    dmem_rdata = 32'hBEEF_1234; dmem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vec++; if (StallM !== 1'b1) begin miss++; $display("FAIL lhu_stall%0d got %b exp 1", k, StallM); end
      @(posedge clk); #1;
      vec++; if (outputs.RegWrite !== 1'b0) begin
        miss++; $display("FAIL lhu_bubble%0d got rw=%b exp 0", k, outputs.RegWrite); end
      @(negedge clk);
    end
    dmem_ack = 1'b1; #1;
    vec++; if ({dmem_req, StallM} !== 2'b10) begin
      miss++; $display("FAIL lhu_ack_cycle got %b exp 10", {dmem_req, StallM}); end
    @(posedge clk); #1;
    vec++; if ({outputs.RegWrite, outputs.load_data} !== {1'b1, 32'h0000_BEEF}) begin
      miss++; $display("FAIL lhu_data got rw=%b %h exp rw=1 0000beef", outputs.RegWrite, outputs.load_data); end
    @(negedge clk); inputs = '0; dmem_ack = 1'b0;
  endtask

  task automatic test_sb();
    @(negedge clk); inputs = mk(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00AB); dmem_ack = 1'b1; #1;
    vec++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 4'b0010, 32'h200, 32'hABAB_ABAB}) begin
      miss++; $display("FAIL sb_bus got req=%b we=%b be=%b addr=%h wd=%h exp 1 1 0010 200 abababab",
                       dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata); end
    @(posedge clk);
    @(negedge clk); inputs = '0; dmem_ack = 1'b0;
  endtask

  task automatic test_misalign();
    @(negedge clk); inputs = mk(1'b1, 1'b0, 3'b010, 32'h302, 32'h0); dmem_ack = 1'b0; #1;
    vec++; if ({misalignM, dmem_req} !== 2'b10) begin
      miss++; $display("FAIL misalign_pulse got %b exp 10", {misalignM, dmem_req}); end
    @(posedge clk); #1;
    vec++; if (outputs.RegWrite !== 1'b0) begin miss++; $display("FAIL misalign_bubble got %b exp 0", outputs.RegWrite); end
    @(negedge clk); inputs = '0; #1;
    vec++; if (misalignM !== 1'b0) begin miss++; $display("FAIL misalign_clear got %b exp 0", misalignM); end
  endtask

  task automatic test_flush_wait();
    @(negedge clk); inputs = mk(1'b1, 1'b0, 3'b010, 32'h400, 32'h0); dmem_ack = 1'b0; #1;
    vec++; if ({dmem_req, StallM} !== 2'b11) begin miss++; $display("FAIL fw_start got %b exp 11", {dmem_req, StallM}); end
    @(posedge clk);
    @(negedge clk); flushM = 1'b1; #1;
    vec++; if (dmem_req !== 1'b1) begin miss++; $display("FAIL fw_req_held got %b exp 1", dmem_req); end
    @(posedge clk); #1;
    vec++; if (outputs.RegWrite !== 1'b0) begin miss++; $display("FAIL fw_bubble got %b exp 0", outputs.RegWrite); end
    @(negedge clk); flushM = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222; #1;
    vec++; if ({dmem_req, StallM} !== 2'b10) begin miss++; $display("FAIL fw_ack got %b exp 10", {dmem_req, StallM}); end
    @(posedge clk); #1;
    vec++; if (outputs.RegWrite !== 1'b0) begin miss++; $display("FAIL fw_discard got %b exp 0", outputs.RegWrite); end
    @(negedge clk); inputs = '0; dmem_ack = 1'b0; #1;
    vec++; if (dmem_req !== 1'b0) begin miss++; $display("FAIL fw_idle got %b exp 0", dmem_req); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk); inputs = mk(1'b1, 1'b0, 3'b010, 32'h500, 32'h0); dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1; inputs = '0; #1;
    vec++; if (dmem_req !== 1'b1) begin miss++; $display("FAIL rw_req_in_reset got %b exp 1", dmem_req); end
    @(posedge clk); #1;
    vec++; if ({dmem_req, StallM, outputs} !== '0) begin
      miss++; $display("FAIL rw_after_reset got req=%b stall=%b out=%h exp all 0", dmem_req, StallM, outputs); end
    @(negedge clk); reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    vec++; if ({dmem_req, StallM} !== 2'b00) begin miss++; $display("FAIL rw_late_ack got %b exp 00", {dmem_req, StallM}); end
    @(posedge clk); #1;
    vec++; if (outputs !== '0) begin miss++; $display("FAIL rw_late_ack_out got %h exp 0", outputs); end
    @(negedge clk); dmem_ack = 1'b0;
  endtask

  task automatic test_random(int n);
    for (int i = 0; i < n; i++) begin
      exmem_t      e;
      memwb_t      exp_out;
      int unsigned kind, dly;
      logic        fl, access, mis, memop;
      logic [31:0] rd;
      kind = $urandom_range(0, 2);
      e = mk(kind == 1, kind == 2, 3'($urandom_range(0, 7)), $urandom, $urandom);
      e.Rd = 5'($urandom); e.PCPlus4 = $urandom; e.ImmExt = $urandom;
      e.ResultSrc = 2'($urandom); e.RegWrite = 1'($urandom);
      e.valid = ($urandom_range(0, 9) != 0);
      fl     = ($urandom_range(0, 9) == 0);
      rd     = $urandom;
      dly    = $urandom_range(0, 3);
      access = e.valid & (e.MemRead | e.MemWrite);
      mis    = access & ~fl & m_misaligned(e);
      memop  = access & ~fl & ~mis;
      if (!memop) dly = 0;
      exp_out = (memop || (e.valid && !access && !fl)) ? m_expect(e, rd) : '0;
      @(negedge clk);
      inputs = e; flushM = fl; dmem_rdata = rd;
      dmem_ack = memop ? (dly == 0) : 1'($urandom);
      for (int k = 0; k <= int'(dly); k++) begin
        #1;
        vec++; if (dmem_req !== memop) begin
          miss++; $display("FAIL rnd%0d_req got %b exp %b", i, dmem_req, memop); end
        vec++; if (StallM !== (memop && k < int'(dly))) begin
          miss++; $display("FAIL rnd%0d_stall c%0d got %b exp %b", i, k, StallM, memop && k < int'(dly)); end
        vec++; if (misalignM !== (mis && k == 0)) begin
          miss++; $display("FAIL rnd%0d_misalign got %b exp %b", i, misalignM, mis); end
        if (memop) begin
          vec++; if ({dmem_we, dmem_addr} !== {e.MemWrite, e.ALUResult & 32'hFFFF_FFFC}) begin
            miss++; $display("FAIL rnd%0d_addr got we=%b %h exp we=%b %h", i, dmem_we, dmem_addr,
                             e.MemWrite, e.ALUResult & 32'hFFFF_FFFC); end
          if (e.MemWrite) begin
            vec++; if ({dmem_be, dmem_wdata} !== {m_be(e), m_wdata(e)}) begin
              miss++; $display("FAIL rnd%0d_lanes got be=%b wd=%h exp be=%b wd=%h", i, dmem_be, dmem_wdata,
                               m_be(e), m_wdata(e)); end
          end
        end
        @(posedge clk); #1;
        if (k < int'(dly)) begin
          vec++; if (outputs !== '0) begin miss++; $display("FAIL rnd%0d_bubble got %h exp 0", i, outputs); end
          @(negedge clk);
          dmem_ack = (k + 1 == int'(dly));
        end else begin
          vec++; if (outputs !== exp_out) begin
            miss++; $display("FAIL rnd%0d_memwb got %h exp %h", i, outputs, exp_out); end
        end
      end
    end
    @(negedge clk); inputs = '0; flushM = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lhu_delay();
    test_sb();
    test_misalign();
    test_flush_wait();
    test_reset_in_wait();
    test_random(300);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
